// File: rtl/bus_rsp_mux.sv
// Response mux: steers the addressed slave's ready/data back to the master and turns unmapped or hung accesses into error responses.
// Latency >= 2 cycles from request; no backpressure, the slave ready is the only stall source and it is bounded by TIMEOUT_CYCLES.
// Optional error log (last errored address, saturating error count) is built when BUS_RSP_ERR_LOG_EN is defined.
module bus_rsp_mux #(
    parameter int              ADDR_WIDTH     = 32,
    parameter int              ADDR_IDX_WIDTH = 3,
    parameter int              DATA_WIDTH     = 32,
    parameter logic [7:0]      SLV_MAP        = 8'b0001_1111,
    parameter int              TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    m_req_i,
    input  logic [ADDR_WIDTH-1:0]   m_addr_i,
    output logic                    m_busy_o,
    output logic                    m_rdy_o,
    output logic                    m_err_o,
    output logic [DATA_WIDTH-1:0]   m_rd_data_o,
    input  logic [7:0]              s_rdy_i,
    input  logic [8*DATA_WIDTH-1:0] s_rd_data_i,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    output logic [7:0]              err_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                    state_q, state_d;
    logic [ADDR_IDX_WIDTH-1:0] idx_q, idx_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      rdy_q, rdy_d;
    logic                      err_q, err_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;

    logic [ADDR_IDX_WIDTH-1:0] req_idx;
    logic                      sel_rdy;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic                      timeout;

    assign req_idx  = m_addr_i[ADDR_WIDTH-1 -: ADDR_IDX_WIDTH];
    assign sel_rdy  = s_rdy_i[idx_q];
    assign sel_data = s_rd_data_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign timeout  = (cnt_q == TO_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (m_req_i) begin
                    idx_d   = req_idx;
                    cnt_d   = '0;
                    state_d = SLV_MAP[req_idx] ? S_WAIT : S_ERR;
                end
            end
            S_WAIT: begin
                if (sel_rdy || timeout) state_d = S_IDLE;
                else                    cnt_d   = cnt_q + 16'd1;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response is registered: computed here, presented the cycle the FSM returns to IDLE.
    always_comb begin
        rdy_d  = 1'b0;
        err_d  = 1'b0;
        data_d = data_q;
        case (state_q)
            S_WAIT: begin
                if (sel_rdy) begin
                    rdy_d  = 1'b1;
                    data_d = sel_data;
                end else if (timeout) begin
                    rdy_d  = 1'b1;
                    err_d  = 1'b1;
                    data_d = '0;
                end
            end
            S_ERR: begin
                rdy_d  = 1'b1;
                err_d  = 1'b1;
                data_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            rdy_q  <= rdy_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    assign m_busy_o    = (state_q != S_IDLE);
    assign m_rdy_o     = rdy_q;
    assign m_err_o     = err_q;
    assign m_rd_data_o = data_q;

`ifdef BUS_RSP_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic [7:0]            err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q     <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (state_q == S_IDLE && m_req_i) addr_q <= m_addr_i;
            if (rdy_d && err_d) begin
                err_addr_q <= addr_q;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;
`else
    // Only the index bits of the address matter without the error log.
    logic unused_addr_bits;
    assign unused_addr_bits = ^m_addr_i[ADDR_WIDTH-ADDR_IDX_WIDTH-1:0];
    assign err_addr_o = '0;
    assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_bus_rsp_mux.sv
// Bench for bus_rsp_mux: directed test-plan steps followed by randomized transactions against a per-transaction timing model.
module tb_bus_rsp_mux;

    localparam int         T   = 16;
    localparam logic [7:0] MAP = 8'b0001_1111;
`ifdef BUS_RSP_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         m_req_i = 1'b0;
    logic [31:0]  m_addr_i = '0;
    logic         m_busy_o, m_rdy_o, m_err_o;
    logic [31:0]  m_rd_data_o;
    logic [7:0]   s_rdy_i = '0;
    logic [255:0] s_rd_data_i = '0;
    logic [31:0]  err_addr_o;
    logic [7:0]   err_cnt_o;

    int vecs = 0;
    int misses = 0;

    logic [31:0] hold_data = '0;
    logic [31:0] e_addr = '0;
    logic [7:0]  e_cnt = '0;
    logic [7:0]  noise_or = '0;

    bus_rsp_mux #(
        .ADDR_WIDTH(32), .ADDR_IDX_WIDTH(3), .DATA_WIDTH(32),
        .SLV_MAP(MAP), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m_req_i(m_req_i), .m_addr_i(m_addr_i),
        .m_busy_o(m_busy_o), .m_rdy_o(m_rdy_o), .m_err_o(m_err_o),
        .m_rd_data_o(m_rd_data_o),
        .s_rdy_i(s_rdy_i), .s_rd_data_i(s_rd_data_i),
        .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction. Model: unmapped -> error 2 cycles after request; mapped with ready first
    // seen d cycles after request -> data at d+1 if d <= T, else error at T+1.
    task automatic run_txn(input logic [31:0] addr, input int dly, input bit ign,
                           input bit chain, input bit started, input logic [31:0] nxt_addr);
        logic [2:0]  idx;
        bit          mapped, exp_err, first;
        int          resp;
        logic [31:0] slv_dat [8];
        logic [31:0] exp_data;
        idx     = addr[31:29];
        mapped  = MAP[idx];
        exp_err = !mapped || (dly > T);
        resp    = !mapped ? 2 : ((dly <= T) ? dly + 1 : T + 1);
        for (int i = 0; i < 8; i++) slv_dat[i] = $urandom;
        exp_data = exp_err ? 32'h0 : slv_dat[idx];
        first = 1'b1;
        for (int rel = (started ? 1 : 0); rel <= resp; rel++) begin
            @(posedge clk_i); #1;
            m_req_i  = (rel == 0) || (ign && rel == 1) || (chain && rel == resp);
            m_addr_i = (rel == 0) ? addr : ((rel == resp) ? nxt_addr : 32'($urandom));
            if (first) begin
                for (int i = 0; i < 8; i++) s_rd_data_i[i*32 +: 32] = slv_dat[i];
                first = 1'b0;
            end
            s_rdy_i      = 8'($urandom) | noise_or;
            s_rdy_i[idx] = mapped && (rel >= 1) && (rel >= dly);
            @(negedge clk_i);
            chk("busy", 64'(m_busy_o), 64'((rel >= 1) && (rel < resp)));
            chk("rdy", 64'(m_rdy_o), 64'(rel == resp));
            if (rel == resp) begin
                chk("err", 64'(m_err_o), 64'(exp_err));
                hold_data = exp_data;
                if (LOG_EN && exp_err) begin
                    e_addr = addr;
                    if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
                end
            end
            chk("data", 64'(m_rd_data_o), 64'(hold_data));
            chk("err_cnt", 64'(err_cnt_o), 64'(e_cnt));
            chk("err_addr", 64'(err_addr_o), 64'(e_addr));
        end
    endtask

    initial begin
        bit          prev_chain;
        bit          cur_chain;
        logic [31:0] cur_addr;
        logic [31:0] nxt;

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy", 64'(m_busy_o), 64'd0);
        chk("rst_rdy", 64'(m_rdy_o), 64'd0);
        chk("rst_err", 64'(m_err_o), 64'd0);
        chk("rst_data", 64'(m_rd_data_o), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        chk("rst_err_addr", 64'(err_addr_o), 64'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // Mapped read to timer, ready two cycles after request
        run_txn(32'h4000_0010, 2, 1'b0, 1'b0, 1'b0, 32'h0);

        // Slave 0 ready held high while slave 1 is addressed
        noise_or = 8'h01;
        run_txn(32'h2000_0000, 11, 1'b0, 1'b0, 1'b0, 32'h0);
        noise_or = 8'h00;

        // Unmapped slave 7
        run_txn(32'hE000_0000, 1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Timeout on gpio, then ready exactly at the counter limit
        run_txn(32'h8000_0000, 100, 1'b0, 1'b0, 1'b0, 32'h0);
        run_txn(32'h8000_0000, T, 1'b0, 1'b0, 1'b0, 32'h0);

        // Ignored request during WAIT, then request in the response cycle
        run_txn(32'h0000_0100, 3, 1'b1, 1'b1, 1'b0, 32'h6000_0000);
        run_txn(32'h6000_0000, 2, 1'b0, 1'b0, 1'b1, 32'h0);

        // Randomized transactions, optionally chained back-to-back
        prev_chain = 1'b0;
        cur_addr   = $urandom;
        for (int n = 0; n < 40; n++) begin
            cur_chain = (n != 39) && ($urandom_range(0, 1) == 1);
            nxt       = $urandom;
            run_txn(cur_addr, $urandom_range(1, T + 4), ($urandom_range(0, 1) == 1),
                    cur_chain, prev_chain, nxt);
            prev_chain = cur_chain;
            cur_addr   = cur_chain ? nxt : 32'($urandom);
        end

        // Reset asserted mid-WAIT
        @(posedge clk_i); #1;
        m_req_i  = 1'b1;
        m_addr_i = 32'h0000_0040;
        s_rdy_i  = 8'h00;
        @(posedge clk_i); #1;
        m_req_i = 1'b0;
        @(posedge clk_i); #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_busy", 64'(m_busy_o), 64'd0);
        chk("arst_rdy", 64'(m_rdy_o), 64'd0);
        chk("arst_err", 64'(m_err_o), 64'd0);
        chk("arst_data", 64'(m_rd_data_o), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt_o), 64'd0);
        chk("arst_err_addr", 64'(err_addr_o), 64'd0);
        s_rdy_i = 8'hFF;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("post_rst_rdy", 64'(m_rdy_o), 64'd0);
            chk("post_rst_busy", 64'(m_busy_o), 64'd0);
            chk("post_rst_err_cnt", 64'(err_cnt_o), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end

endmodule

// File: doc/bus_rsp_mux.md
Name: bus_rsp_mux

Overview:
- Response-path counterpart of the bus address decoder.
- Tracks the single outstanding master transaction and steers the addressed slave's ready and read data back to the master.
- Index is taken from the top ADDR_IDX_WIDTH address bits, giving slaves 0..7: ROM, SPM, timer, uart, gpio, then three reserved.
- Converts unmapped accesses and hung slaves into error responses, so the master never stalls forever.

Parameters:
- ADDR_WIDTH, 32, master address width.
- ADDR_IDX_WIDTH, 3, number of top address bits used as slave index (8 slaves).
- DATA_WIDTH, 32, read data width.
- SLV_MAP, 8'b0001_1111, bit n=1 means slave n is populated.
- TIMEOUT_CYCLES, 256, WAIT cycles before a timeout error; legal range 2..65535.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- m_req_i  in  1  master request strobe, 1-cycle pulse, only accepted in IDLE.
- m_addr_i  in  ADDR_WIDTH  master address, sampled with m_req_i.
- m_busy_o  out  1  high while a transaction is outstanding (not IDLE).
- m_rdy_o  out  1  1-cycle response strobe.
- m_err_o  out  1  qualifies m_rdy_o as an error response.
- m_rd_data_o  out  DATA_WIDTH  response data, valid with m_rdy_o, held until the next response.
- s_rdy_i  in  8  per-slave ready, bit n from slave n.
- s_rd_data_i  in  8*DATA_WIDTH  packed slave read data, slave n at [n*DATA_WIDTH +: DATA_WIDTH].
- err_addr_o  out  ADDR_WIDTH  last errored address (optional feature).
- err_cnt_o  out  8  saturating error count (optional feature).

Behaviour:
- Reset (async assert, sync deassert by system):
  - state=IDLE.
  - m_busy_o, m_rdy_o and m_err_o = 0.
  - m_rd_data_o = 0.
  - Index register and timeout counter = 0.
  - err_addr_o = 0, err_cnt_o = 0.
- IDLE, m_req_i=1:
  - Latch idx = m_addr_i[ADDR_WIDTH-1 -: ADDR_IDX_WIDTH].
  - SLV_MAP[idx]=1 -> WAIT with counter cleared.
  - Otherwise -> ERR.
  - m_busy_o rises the cycle after m_req_i.
- WAIT:
  - Only s_rdy_i[idx] is sampled; other slaves' ready is ignored.
  - s_rdy_i[idx]=1: next cycle m_rdy_o=1, m_err_o=0, m_rd_data_o = slave idx data (registered); state -> IDLE.
  - Otherwise counter increments.
  - Counter == TIMEOUT_CYCLES-1 with no ready: next cycle m_rdy_o=1, m_err_o=1, m_rd_data_o=0; state -> IDLE.
  - Ready and timeout in the same cycle: ready wins, normal response.
- ERR:
  - Single cycle; next cycle m_rdy_o=1, m_err_o=1, m_rd_data_o=0; state -> IDLE.
- Latency:
  - Request in cycle N, slave ready in cycle N+1 -> m_rdy_o in cycle N+2 (minimum 2).
  - Unmapped access -> m_rdy_o in cycle N+2.
  - Timeout -> m_rdy_o in cycle N+1+TIMEOUT_CYCLES.
- m_req_i while not in IDLE is ignored (protocol violation, no side effect). m_busy_o falls in the same cycle m_rdy_o is asserted, so a new m_req_i is accepted in the m_rdy_o cycle.
- m_rdy_o is exactly one cycle wide; never asserted in back-to-back cycles.
- Reset asserted mid-transaction: aborts immediately, no response is issued.

Optional Feature:
- Macro: BUS_RSP_ERR_LOG_EN.
- Defined:
  - Every error response (unmapped or timeout) loads err_addr_o with the full latched request address.
  - The same response increments err_cnt_o, saturating at 8'hFF.
  - Both update in the same cycle as m_err_o and are cleared only by reset.
- Undefined:
  - No address register or counter is built.
  - err_addr_o and err_cnt_o are tied to 0.

Test Plan:
- Mapped read: req addr 0x4000_0010, s_rdy_i[2]=1 two cycles later, slave 2 data 0xDEAD_BEEF -> m_rdy_o=1, m_err_o=0, m_rd_data_o=0xDEAD_BEEF exactly one cycle after ready.
- Wrong-slave ready: req to 0x2000_0000 (idx 1) with s_rdy_i=8'b0000_0001 for 10 cycles, then bit 1 -> response only after bit 1 rises, carrying slave 1 data.
- Unmapped: req addr 0xE000_0000 -> m_rdy_o=m_err_o=1 at N+2, data 0; with BUS_RSP_ERR_LOG_EN, err_addr_o=0xE000_0000 and err_cnt_o=1.
- Timeout: TIMEOUT_CYCLES=16, req to gpio 0x8000_0000, no ready -> error response at N+17; ready at N+16 (same cycle as counter limit) -> normal response instead.
- Back-to-back and ignored request: pulse m_req_i during WAIT -> no effect; new req in the m_rdy_o cycle -> accepted, second response follows normally.
- Reset mid-WAIT: drop rst_n_i -> all outputs 0 asynchronously; after release, no stale m_rdy_o and err_cnt_o=0.
